param_mux: RTL and testbench



---
 rtl/param_mux.sv | 45 ++++
 tb/tb_param_mux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/param_mux.sv
// N-to-1 single-bit multiplexer with a registered copy of the selected bit
// and of the out-of-range select flag.
module param_mux #(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i,
  input  logic [SW-1:0] s,
  output logic          y,
  output logic          sel_err,
  output logic          y_q,
  output logic          sel_err_q
);

  localparam int NPOW = 1 << SW;

  generate
    if (N == NPOW) begin : g_pow2
      // Every select code names a real input, so the flag can never rise.
      assign y       = i[s];
      assign sel_err = 1'b0;
    end else begin : g_pad
      // Unused codes land on zero padding, which gives y = 0 for s >= N.
      localparam int PAD = NPOW - N;
      localparam logic [SW-1:0] S_MAX = SW'(N - 1);
      logic [NPOW-1:0] i_ext;
      assign i_ext   = {{PAD{1'b0}}, i};
      assign y       = i_ext[s];
      assign sel_err = (s > S_MAX);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_param_mux.sv
// Bench for param_mux at N=8, N=5 and N=2, checked against an arithmetic
// reference of the select rule plus a one-cycle register model.
module tb_param_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] i8;
  logic [2:0] s8;
  logic [4:0] i5;
  logic [2:0] s5;
  logic [1:0] i2;
  logic       s2;
  logic       y8, e8, yq8, eq8;
  logic       y5, e5, yq5, eq5;
  logic       y2, e2, yq2, eq2;

  int total = 0;
  int bad   = 0;

  param_mux #(.N(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .s(s8),
    .y(y8), .sel_err(e8), .y_q(yq8), .sel_err_q(eq8)
  );
  param_mux #(.N(5)) u_n5 (
    .clk(clk), .rst_n(rst_n), .i(i5), .s(s5),
    .y(y5), .sel_err(e5), .y_q(yq5), .sel_err_q(eq5)
  );
  param_mux #(.N(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .i(i2), .s(s2),
    .y(y2), .sel_err(e2), .y_q(yq2), .sel_err_q(eq2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: selected bit of the integer value, zero when out of range
  function automatic logic ref_y(input int n, input int iv, input int sv);
    if (sv >= n) return 1'b0;
    return ((iv >> sv) & 1) != 0;
  endfunction

  function automatic logic ref_err(input int n, input int sv);
    return sv >= n;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_comb();
    check("y8",   y8, ref_y(8, int'(i8), int'(s8)));
    check("err8", e8, ref_err(8, int'(s8)));
    check("y5",   y5, ref_y(5, int'(i5), int'(s5)));
    check("err5", e5, ref_err(5, int'(s5)));
    check("y2",   y2, ref_y(2, int'(i2), int'(s2)));
    check("err2", e2, ref_err(2, int'(s2)));
  endtask

  // driver: random inputs on all three instances
  task automatic drive_random();
    i8 = 8'($urandom_range(0, 255));
    s8 = 3'($urandom_range(0, 7));
    i5 = 5'($urandom_range(0, 31));
    s5 = 3'($urandom_range(0, 7));
    i2 = 2'($urandom_range(0, 3));
    s2 = 1'($urandom_range(0, 1));
  endtask

  // scoreboard for the registered path: expected {y_q, sel_err_q} per instance
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  initial begin
    rst_n = 1'b0;
    i8 = 8'h00; s8 = 3'd0; i5 = 5'd0; s5 = 3'd0; i2 = 2'd0; s2 = 1'b0;
    #12;
    check("rst_yq8", yq8, 1'b0);
    check("rst_eq8", eq8, 1'b0);
    check("rst_yq5", yq5, 1'b0);
    check("rst_eq5", eq5, 1'b0);
    check("rst_yq2", yq2, 1'b0);

    // exhaustive N=8 sweep; registered outputs stay in reset
    for (int iv = 0; iv < 256; iv++) begin
      for (int sv = 0; sv < 8; sv++) begin
        i8 = 8'(iv);
        s8 = 3'(sv);
        #10;
        check("sweep_y8", y8, ((iv >> sv) & 1) != 0);
        check("sweep_err8", e8, 1'b0);
      end
    end
    check("sweep_hold_yq8", yq8, 1'b0);

    // spot checks N=8
    i8 = 8'b1000_0000; s8 = 3'd7; #1; check("spot_msb", y8, 1'b1);
    s8 = 3'd6; #1; check("spot_b6", y8, 1'b0);
    i8 = 8'hFE; s8 = 3'd0; #1; check("spot_fe", y8, 1'b0);
    i8 = 8'h01; s8 = 3'd0; #1; check("spot_01", y8, 1'b1);

    // out of range N=5
    i5 = 5'b11111;
    s5 = 3'd4; #1; check("n5_s4_y", y5, 1'b1); check("n5_s4_err", e5, 1'b0);
    for (int sv = 5; sv < 8; sv++) begin
      s5 = 3'(sv);
      #1;
      check("n5_oor_y", y5, 1'b0);
      check("n5_oor_err", e5, 1'b1);
    end

    // N=2
    i2 = 2'b10;
    s2 = 1'b0; #1; check("n2_s0_y", y2, 1'b0); check("n2_s0_err", e2, 1'b0);
    s2 = 1'b1; #1; check("n2_s1_y", y2, 1'b1); check("n2_s1_err", e2, 1'b0);

    // registered path, N=8, i=A5
    @(negedge clk);
    i8 = 8'hA5; s8 = 3'd0; i5 = 5'd0; s5 = 3'd5;
    #1;
    check("reg_pre_yq8", yq8, 1'b0);
    check("reg_pre_eq5", eq5, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reg_e1_yq8", yq8, 1'b1);
    check("reg_e1_eq5", eq5, 1'b1);
    @(negedge clk);
    s8 = 3'd1; s5 = 3'd0;
    #2;
    check("reg_hold_yq8", yq8, 1'b1);
    check("reg_hold_eq5", eq5, 1'b1);
    @(posedge clk); #1;
    check("reg_e2_yq8", yq8, 1'b0);
    check("reg_e2_eq5", eq5, 1'b0);

    // async reset mid-run with y_q = 1
    @(negedge clk);
    s8 = 3'd2;
    @(posedge clk); #1;
    check("areset_pre_yq8", yq8, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_yq8", yq8, 1'b0);
    check("areset_y8", y8, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized phase with occasional async reset between edges
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive_random();
      #1;
      check_comb();
      exp_q.push_back({ref_y(8, int'(i8), int'(s8)), ref_err(8, int'(s8)),
                       ref_y(5, int'(i5), int'(s5)), ref_err(5, int'(s5)),
                       ref_y(2, int'(i2), int'(s2)), ref_err(2, int'(s2))});
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 1'b1, 1'b0);
      end else begin
        exp_v = exp_q.pop_front();
        check("rnd_yq8", yq8, exp_v[5]);
        check("rnd_eq8", eq8, exp_v[4]);
        check("rnd_yq5", yq5, exp_v[3]);
        check("rnd_eq5", eq5, exp_v[2]);
        check("rnd_yq2", yq2, exp_v[1]);
        check("rnd_eq2", eq2, exp_v[0]);
      end
      if ($urandom_range(0, 15) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("rnd_rst_yq8", yq8, 1'b0);
        check("rnd_rst_eq5", eq5, 1'b0);
        check("rnd_rst_yq2", yq2, 1'b0);
        check_comb();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
